// File: rtl/edge_monitor_pkg.sv
// edge_monitor_pkg: shared types and helpers for the edge_monitor block.
//   em_mode_e  - detection mode encoding (rise / fall / both / off)
//   em_state_e - priming FSM states
//   popcount   - number of set bits among the low 'width' bits of a vector
package edge_monitor_pkg;

  typedef enum logic [1:0] {EM_RISE, EM_FALL, EM_BOTH, EM_OFF} em_mode_e;

  typedef enum logic {EM_UNPRIMED, EM_PRIMED} em_state_e;

  // Widest supported bus and the count width needed to hold its popcount.
  localparam int unsigned EM_MAX_W = 32;
  localparam int unsigned EM_PC_W  = 6;

  // Counts set bits in v[width-1:0]; bits at or above 'width' are ignored.
  function automatic logic [EM_PC_W-1:0] popcount(input logic [EM_MAX_W-1:0] v,
                                                  input int unsigned        width);
    logic [EM_PC_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < EM_MAX_W; i++) begin
      if ((i < width) && v[i]) n = n + EM_PC_W'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/edge_stretch.sv
// edge_stretch: per-bit reloadable pulse stretcher.
//   i_clk   - clock (posedge)
//   i_rst_n - synchronous active-low reset; drops the pulse at once
//   i_det   - one-cycle detect strobe; (re)starts the pulse
//   o_pulse - registered pulse, high for STRETCH cycles after the last detect
module edge_stretch #(
  parameter int unsigned STRETCH = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_det,
  output logic o_pulse
);

  // The detect cycle itself is the first high cycle, so the counter holds
  // the number of extra cycles still to come.
  localparam logic [3:0] RELOAD = 4'(STRETCH - 1);

  logic [3:0] r_cnt;
  logic       r_pulse;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (i_det) begin
      r_cnt   <= RELOAD;
      r_pulse <= 1'b1;
    end else if (r_cnt != 4'd0) begin
      r_cnt   <= r_cnt - 4'd1;
      r_pulse <= 1'b1;
    end else begin
      r_pulse <= 1'b0;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/edge_monitor.sv
// edge_monitor: multi-bit edge detector with sticky flags and event counter.
//   clk, rst_n  - clock (posedge) and synchronous active-low reset
//   din         - monitored bus (WIDTH bits)
//   mode        - 0 rise, 1 fall, 2 both, 3 off (applied to the current compare)
//   clr         - clears sticky flags and counter (a coincident edge survives)
//   edge_o      - per-bit edge pulse (stretched when EDGE_MONITOR_STRETCH_EN)
//   sticky_o    - per-bit flags, held until clr
//   any_edge_o  - OR of the detect vector
//   edge_cnt_o  - saturating count of detected bit-edges
// Build option: define EDGE_MONITOR_STRETCH_EN to hold each edge_o bit for
// STRETCH cycles (retriggerable); otherwise edge_o is a one-cycle pulse.
module edge_monitor
  import edge_monitor_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned STRETCH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic [WIDTH-1:0] edge_o,
  output logic [WIDTH-1:0] sticky_o,
  output logic             any_edge_o,
  output logic [CNT_W-1:0] edge_cnt_o
);

  localparam int unsigned CFG_OK = ((WIDTH >= 1) && (WIDTH <= EM_MAX_W) &&
                                    (STRETCH >= 1) && (STRETCH <= 15)) ? 1 : 0;

  // One spare bit above the wider of counter and popcount catches overflow.
  localparam int unsigned SUM_W = ((CNT_W > EM_PC_W) ? CNT_W : EM_PC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  if (CFG_OK == 0) begin : g_cfg_check
    $fatal(1, "edge_monitor: WIDTH must be 1..32 and STRETCH 1..15");
  end

  em_state_e          r_state;
  em_state_e          w_state_nxt;
  logic [WIDTH-1:0]   r_cur;
  logic [WIDTH-1:0]   w_det;
  logic [WIDTH-1:0]   r_sticky;
  logic               r_any;
  logic [CNT_W-1:0]   r_cnt;
  logic [EM_PC_W-1:0] w_pc;
  logic [SUM_W-1:0]   w_base;
  logic [SUM_W-1:0]   w_sum;
  logic [CNT_W-1:0]   w_cnt_nxt;

  // Priming FSM: state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= EM_UNPRIMED;
    else        r_state <= w_state_nxt;
  end

  // Priming FSM: the first sample after reset only loads history.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EM_UNPRIMED: w_state_nxt = EM_PRIMED;
      EM_PRIMED:   w_state_nxt = EM_PRIMED;
      default:     w_state_nxt = EM_UNPRIMED;
    endcase
  end

  // Previous sample of the bus.
  always_ff @(posedge clk) begin
    if (!rst_n) r_cur <= '0;
    else        r_cur <= din;
  end

  // Detect vector: current input against last sample, gated by mode.
  always_comb begin
    w_det = '0;
    if (r_state == EM_PRIMED) begin
      case (em_mode_e'(mode))
        EM_RISE: w_det = din & ~r_cur;
        EM_FALL: w_det = ~din & r_cur;
        EM_BOTH: w_det = din ^ r_cur;
        default: w_det = '0;
      endcase
    end
  end

  // Saturating counter next value; clr restarts from this cycle's edges.
  always_comb begin
    w_pc      = popcount(EM_MAX_W'(w_det), WIDTH);
    w_base    = clr ? '0 : SUM_W'(r_cnt);
    w_sum     = w_base + SUM_W'(w_pc);
    w_cnt_nxt = (w_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : w_sum[CNT_W-1:0];
  end

  // Unstretched status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sticky <= '0;
      r_any    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sticky <= clr ? w_det : (r_sticky | w_det);
      r_any    <= |w_det;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign sticky_o   = r_sticky;
  assign any_edge_o = r_any;
  assign edge_cnt_o = r_cnt;

`ifdef EDGE_MONITOR_STRETCH_EN
  logic [WIDTH-1:0] w_edge_str;

  for (genvar g = 0; g < WIDTH; g++) begin : g_stretch
    edge_stretch #(
      .STRETCH (STRETCH)
    ) u_stretch (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_det   (w_det[g]),
      .o_pulse (w_edge_str[g])
    );
  end

  assign edge_o = w_edge_str;
`else
  logic [WIDTH-1:0] r_edge;

  // One-cycle edge pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) r_edge <= '0;
    else        r_edge <= w_det;
  end

  assign edge_o = r_edge;
`endif

endmodule
